// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, datapath mux selects, ALUOp and ALU control codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle sequencer (master) and the datapath
// (slave): instruction fields and flags in, mux selects and enables out.
interface multicycle_control_fsm_if #(
   parameter int STATE_W = 4
);
   logic [6:0]         op;
   logic [2:0]         funct3;
   logic               funct7;
   logic               zero;
   logic               PCWrite;
   logic               AdrSrc;
   logic               MemWrite;
   logic               IRWrite;
   logic [1:0]         ResultSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [2:0]         ALUControl;
   logic [1:0]         ImmSrc;
   logic               RegWrite;
   logic [STATE_W-1:0] state;

   modport master (
      input  op, funct3, funct7, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ALUControl, ImmSrc, RegWrite, state
   );

   modport slave (
      output op, funct3, funct7, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ALUControl, ImmSrc, RegWrite, state
   );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU control decoder shared with the single-cycle core: maps ALUOp plus
// funct3/funct7/op[5] to the ALU operation code.
import riscv_ctrl_pkg::*;

module alu_decoder (
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         default: begin
            case (funct3)
               // sub only for R-type with instr[30] set; addi never subtracts
               3'b000:  alu_control = (op5 & funct7) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle RV32I datapath. Defining
// CTRL_ILLEGAL_TRAP_EN adds a sticky TRAP state and the illegal_instr port.
import riscv_ctrl_pkg::*;

module multicycle_control_fsm #(
   parameter int STATE_W = 4
) (
   input logic                    clk,
   input logic                    rst,
   multicycle_control_fsm_if.master bus
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                   illegal_instr
`endif
);

   state_t     cur;
   state_t     nxt;
   state_t     out_st;
   logic       pc_update;
   logic       branch;
   logic       ir_write;
   logic       reg_write;
   logic       mem_write;
   logic [1:0] alu_op;

   always_ff @(posedge clk) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH:  nxt = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_EXECR;
               OP_I:         nxt = S_EXECI;
               OP_BEQ:       nxt = S_BEQ;
               OP_JAL:       nxt = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default:      nxt = S_TRAP;
`else
               default:      nxt = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:  nxt = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: nxt = S_MEMWB;
         S_EXECR, S_EXECI, S_JAL: nxt = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_TRAP:    nxt = S_TRAP;
`endif
         default:   nxt = S_FETCH;
      endcase
   end

   // While rst is high the selects show FETCH values; enables are gated below.
   always_comb begin
      out_st        = rst ? S_FETCH : cur;
      pc_update     = 1'b0;
      branch        = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      alu_op        = ALUOP_ADD;
      bus.AdrSrc    = 1'b0;
      bus.ResultSrc = RES_ALUOUT;
      bus.ALUSrcA   = SRCA_PC;
      bus.ALUSrcB   = SRCB_RS2;
      case (out_st)
         S_FETCH: begin
            ir_write      = 1'b1;
            pc_update     = 1'b1;
            bus.ALUSrcB   = SRCB_FOUR;
            bus.ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: bus.AdrSrc = 1'b1;
         S_MEMWB: begin
            bus.ResultSrc = RES_DATA;
            reg_write     = 1'b1;
         end
         S_MEMWRITE: begin
            bus.AdrSrc = 1'b1;
            mem_write  = 1'b1;
         end
         S_EXECR: begin
            bus.ALUSrcA = SRCA_RS1;
            alu_op      = ALUOP_FUNCT;
         end
         S_EXECI: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
            alu_op      = ALUOP_FUNCT;
         end
         S_ALUWB: reg_write = 1'b1;
         S_JAL: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_FOUR;
            pc_update   = 1'b1;
         end
         S_BEQ: begin
            bus.ALUSrcA = SRCA_RS1;
            alu_op      = ALUOP_SUB;
            branch      = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.PCWrite  = ~rst & (pc_update | (branch & bus.zero));
   assign bus.IRWrite  = ~rst & ir_write;
   assign bus.RegWrite = ~rst & reg_write;
   assign bus.MemWrite = ~rst & mem_write;
   assign bus.state    = STATE_W'(cur);

   always_comb begin
      case (bus.op)
         OP_SW:   bus.ImmSrc = IMM_S;
         OP_BEQ:  bus.ImmSrc = IMM_B;
         OP_JAL:  bus.ImmSrc = IMM_J;
         default: bus.ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (bus.funct3),
      .funct7      (bus.funct7),
      .op5         (bus.op[5]),
      .alu_control (bus.ALUControl)
   );

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal_instr = ~rst & (cur == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: randomized instruction stream
// checked cycle by cycle against a per-instruction-class reference model.
module tb_multicycle_control_fsm;

   typedef int iq_t[$];

   typedef struct {
      int         st;
      bit         pcw, irw, rw, mw, adr, ill, chk_alu;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
   } exp_t;

   logic clk;
   logic rst;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_instr;
`endif

   multicycle_control_fsm_if #(.STATE_W(4)) bus ();

   multicycle_control_fsm #(.STATE_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef CTRL_ILLEGAL_TRAP_EN
      ,
      .illegal_instr (illegal_instr)
`endif
   );

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction-class paths through the controller.
   function automatic iq_t path(logic [6:0] op);
      iq_t p;
      case (op)
         7'b0000011: p = '{0, 1, 2, 3, 4};
         7'b0100011: p = '{0, 1, 2, 5};
         7'b0110011: p = '{0, 1, 6, 7};
         7'b0010011: p = '{0, 1, 8, 7};
         7'b1100011: p = '{0, 1, 10};
         7'b1101111: p = '{0, 1, 9, 7};
`ifdef CTRL_ILLEGAL_TRAP_EN
         default:    p = '{0, 1, 11, 11, 11, 11};
`else
         default:    p = '{0, 1};
`endif
      endcase
      return p;
   endfunction

   function automatic exp_t model(int st, bit r, logic [6:0] op, logic [2:0] f3,
                                  logic f7, logic z);
      exp_t e;
      int   s;
      e = '{default: 0};
      e.st = st;
      s = r ? 0 : st;
      e.imm = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
              (op == 7'b1101111) ? 2'd3 : 2'd0;
      e.chk_alu = 1'b1;
      e.alu = 3'd0;
      case (s)
         0:  begin e.irw = 1; e.pcw = 1; e.sb = 2; e.rs = 2; end
         1:  begin e.sa = 1; e.sb = 1; end
         2:  begin e.sa = 2; e.sb = 1; end
         3:  e.adr = 1;
         4:  begin e.rs = 1; e.rw = 1; end
         5:  begin e.adr = 1; e.mw = 1; end
         6, 8: begin
            e.sa = 2;
            e.sb = (s == 8) ? 2'd1 : 2'd0;
            if (f3 == 3'd0) e.alu = (op[5] && f7) ? 3'd1 : 3'd0;
            else            e.chk_alu = 1'b0;
         end
         7:  e.rw = 1;
         9:  begin e.sa = 1; e.sb = 2; e.pcw = 1; end
         10: begin e.sa = 2; e.alu = 3'd1; e.pcw = z; end
         11: e.ill = 1;
         default: ;
      endcase
      if (r) begin
         e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0; e.ill = 0;
      end
      return e;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("state",     int'(bus.state),     e.st);
         check("PCWrite",   int'(bus.PCWrite),   int'(e.pcw));
         check("IRWrite",   int'(bus.IRWrite),   int'(e.irw));
         check("RegWrite",  int'(bus.RegWrite),  int'(e.rw));
         check("MemWrite",  int'(bus.MemWrite),  int'(e.mw));
         check("AdrSrc",    int'(bus.AdrSrc),    int'(e.adr));
         check("ResultSrc", int'(bus.ResultSrc), int'(e.rs));
         check("ALUSrcA",   int'(bus.ALUSrcA),   int'(e.sa));
         check("ALUSrcB",   int'(bus.ALUSrcB),   int'(e.sb));
         check("ImmSrc",    int'(bus.ImmSrc),    int'(e.imm));
         if (e.chk_alu) check("ALUControl", int'(bus.ALUControl), int'(e.alu));
`ifdef CTRL_ILLEGAL_TRAP_EN
         check("illegal_instr", int'(illegal_instr), int'(e.ill));
`endif
      end
   end

   task automatic push_cycle(int st, bit r);
      exp_q.push_back(model(st, r, bus.op, bus.funct3, bus.funct7, bus.zero));
   endtask

   // zmode: 0/1 fixes zero, 2 randomizes it every cycle. abort_at >= 0 raises
   // rst during that step of the path and abandons the instruction.
   task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic f7, int zmode,
                            int abort_at);
      iq_t p;
      p = path(op);
      foreach (p[i]) begin
         if (i == 0) begin
            bus.op     = 7'($urandom);
            bus.funct3 = 3'($urandom);
            bus.funct7 = 1'($urandom);
         end else begin
            bus.op     = op;
            bus.funct3 = f3;
            bus.funct7 = f7;
         end
         bus.zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         if (i == abort_at) begin
            rst = 1'b1;
            push_cycle(p[i], 1'b1);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         push_cycle(p[i], 1'b0);
         @(posedge clk); #1;
      end
   endtask

   logic [6:0] legal_ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1100011, 7'b1101111};
   logic [6:0] bad_ops[3]   = '{7'b1111111, 7'b0110111, 7'b0010111};

   initial begin
      rst        = 1'b1;
      bus.op     = '0;
      bus.funct3 = '0;
      bus.funct7 = 1'b0;
      bus.zero   = 1'b0;
      @(posedge clk); #1;
      push_cycle(0, 1'b1);
      push_cycle(0, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_instr(7'b0000011, 3'b010, 1'b0, 2, -1);
      run_instr(7'b0100011, 3'b010, 1'b0, 2, -1);
      run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);
      run_instr(7'b1100011, 3'b000, 1'b0, 0, -1);
      run_instr(7'b0110011, 3'b000, 1'b1, 2, -1);
      run_instr(7'b0110011, 3'b000, 1'b0, 2, -1);
      run_instr(7'b0010011, 3'b000, 1'b1, 2, -1);
      run_instr(7'b1101111, 3'b000, 1'b0, 2, -1);
`ifndef CTRL_ILLEGAL_TRAP_EN
      run_instr(7'b1111111, 3'b000, 1'b0, 2, -1);
`endif

      for (int n = 0; n < 50; n++) begin
         logic [6:0] op;
         logic [2:0] f3;
         op = legal_ops[$urandom_range(0, 5)];
`ifndef CTRL_ILLEGAL_TRAP_EN
         if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 2)];
`endif
         f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
         run_instr(op, f3, 1'($urandom), 2, -1);
      end

      run_instr(7'b0000011, 3'b010, 1'b0, 2, 3);
      run_instr(7'b0110011, 3'b000, 1'b1, 2, -1);

`ifdef CTRL_ILLEGAL_TRAP_EN
      run_instr(7'b1111111, 3'b000, 1'b0, 2, -1);
      rst = 1'b1;
      push_cycle(11, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(7'b1101111, 3'b000, 1'b0, 2, -1);
`endif

      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
